// File: rtl/mac_prbs_checker.sv
// mac_prbs_checker
// Receive-side PRBS checker for the MAC test path. It locks onto the
// PRBS stream recovered by the DMT receiver. While locked it counts
// checked bits and bit errors so the link BER can be measured.
module mac_prbs_checker #(
    parameter int POLY_LENGTH = 7,
    parameter int POLY_TAP    = 1,
    parameter int LOCK_THRESH = 32,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 SERIAL_CLK,
    input  logic                 MAC_RST,
    input  logic                 DATA_INPUT,
    input  logic                 DATA_INPUT_VALID,
    input  logic                 FRAME_START,
    input  logic                 CNT_CLEAR,
    output logic                 LOCKED,
    output logic                 ERR_FLAG,
    output logic [CNT_WIDTH-1:0] BIT_COUNT,
    output logic [CNT_WIDTH-1:0] ERR_COUNT
);

    typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

    localparam int FILL_W  = $clog2(POLY_LENGTH + 1);
    localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int WIN_W   = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(POLY_LENGTH);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_THRESH);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WINDOW - 1);
    localparam logic [WERR_W-1:0]  WERR_LOSS  = WERR_W'(LOSS_THRESH);

    state_t                 state_q, state_d;
    logic [POLY_LENGTH-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [MATCH_W-1:0]     match_q, match_d, match_inc;
    logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]      win_err_q, win_err_d, win_err_inc;
    logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic                   err_flag_q, err_flag_d;
    logic                   expected_bit, bit_err, hist_zero;

    // Bit 0 of hist_q is the most recent accepted bit.
    // Bit k-1 is the bit accepted k valid cycles earlier.
    assign expected_bit = hist_q[POLY_LENGTH-1] ^ hist_q[POLY_TAP-1];
    assign bit_err      = DATA_INPUT ^ expected_bit;
    assign hist_zero    = (hist_q == '0);
    assign match_inc    = match_q + 1'b1;
    assign win_err_inc  = win_err_q + WERR_W'(bit_err);

    // The BER counters stop at all-ones instead of wrapping to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Next-state logic for acquisition, lock tracking and the BER counters.
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        match_d    = match_q;
        win_cnt_d  = win_cnt_q;
        win_err_d  = win_err_q;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = 1'b0;
        if (FRAME_START) begin
            state_d   = ST_SEARCH;
            fill_d    = '0;
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
        end else begin
            if (DATA_INPUT_VALID) begin
                case (state_q)
                    ST_SEARCH: begin
                        hist_d = {hist_q[POLY_LENGTH-2:0], DATA_INPUT};
                        if (fill_q < FILL_FULL) begin
                            fill_d = fill_q + 1'b1;
                        end else if (bit_err || hist_zero) begin
                            match_d = '0;
                        end else if (match_inc == MATCH_LOCK) begin
                            state_d   = ST_LOCKED;
                            match_d   = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else begin
                            match_d = match_inc;
                        end
                    end
                    ST_LOCKED: begin
                        hist_d    = {hist_q[POLY_LENGTH-2:0], expected_bit};
                        bit_cnt_d = sat_inc(bit_cnt_q);
                        if (bit_err) begin
                            err_cnt_d  = sat_inc(err_cnt_q);
                            err_flag_d = 1'b1;
                        end
                        if (win_err_inc == WERR_LOSS) begin
                            state_d   = ST_SEARCH;
                            fill_d    = '0;
                            match_d   = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else if (win_cnt_q == WIN_LAST) begin
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else begin
                            win_cnt_d = win_cnt_q + 1'b1;
                            win_err_d = win_err_inc;
                        end
                    end
                    default: state_d = ST_SEARCH;
                endcase
            end
            if (CNT_CLEAR) begin
                bit_cnt_d = '0;
                err_cnt_d = '0;
            end
        end
    end

    // All checker state is registered, with a synchronous reset to the search condition.
    always_ff @(posedge SERIAL_CLK) begin
        if (MAC_RST) begin
            state_q    <= ST_SEARCH;
            hist_q     <= '0;
            fill_q     <= '0;
            match_q    <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            match_q    <= match_d;
            win_cnt_q  <= win_cnt_d;
            win_err_q  <= win_err_d;
            bit_cnt_q  <= bit_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign LOCKED    = (state_q == ST_LOCKED);
    assign ERR_FLAG  = err_flag_q;
    assign BIT_COUNT = bit_cnt_q;
    assign ERR_COUNT = err_cnt_q;

endmodule
